// File: rtl/ifft_8_seq_if.sv
// Stream interface of the 8-point inverse FFT: frequency bins in, time samples out.
interface ifft_8_seq_if #(
    parameter int DW = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_real;
    logic signed [DW-1:0] in_imag;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_real;
    logic signed [DW-1:0] out_imag;
    logic                 out_last;

    modport slave (
        input  in_valid, in_real, in_imag, out_ready,
        output in_ready, out_valid, out_real, out_imag, out_last
    );

    modport master (
        output in_valid, in_real, in_imag, out_ready,
        input  in_ready, out_valid, out_real, out_imag, out_last
    );
endinterface

// File: rtl/ifft_8_seq.sv
// Sequential 8-point inverse FFT: loads a frame of bins in bit-reversed order,
// runs 12 in-place radix-2 DIT butterflies (one per clock), then streams the
// time samples out in natural order, divided by 8 and saturated.
module ifft_8_seq #(
    parameter int DW = 8,
    parameter int IW = DW + 5
) (
    input  logic        clk,
    input  logic        rst,
    ifft_8_seq_if.slave bus
);
    localparam int PW = IW + 9;

    localparam logic [1:0] ST_LOAD    = 2'd0;
    localparam logic [1:0] ST_COMPUTE = 2'd1;
    localparam logic [1:0] ST_UNLOAD  = 2'd2;

    // cos/sin of 45 degrees in Q1.7
    localparam logic signed [PW-1:0] C_DIAG = PW'(91);
    localparam logic signed [IW-1:0] SAT_HI = IW'((1 << (DW - 1)) - 1);
    localparam logic signed [IW-1:0] SAT_LO = ~SAT_HI;

    function automatic logic [2:0] rev3(input logic [2:0] k);
        return {k[0], k[1], k[2]};
    endfunction

    // Final 1/8 scaling (floor) followed by saturation to the output width.
    function automatic logic signed [DW-1:0] to_out(input logic signed [IW-1:0] v);
        logic signed [IW-1:0] s;
        s = v >>> 3;
        if (s > SAT_HI)      return SAT_HI[DW-1:0];
        else if (s < SAT_LO) return SAT_LO[DW-1:0];
        else                 return s[DW-1:0];
    endfunction

    logic [1:0]           state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic signed [IW-1:0] mem_re_q [8];
    logic signed [IW-1:0] mem_im_q [8];
    logic signed [IW-1:0] mem_re_d [8];
    logic signed [IW-1:0] mem_im_d [8];
    logic signed [DW-1:0] out_real_q, out_real_d;
    logic signed [DW-1:0] out_imag_q, out_imag_d;
    logic                 out_last_q, out_last_d;

    logic [2:0]           top_addr, bot_addr;
    logic [1:0]           tw_sel;
    logic signed [IW-1:0] a_re, a_im, b_re, b_im, wb_re, wb_im;
    logic signed [PW-1:0] b_sum, b_diff, p_sum, p_diff, p_sum_neg;

    // Butterfly addressing: cnt[3:2] is the stage, cnt[1:0] the butterfly in it;
    // tw_sel is the twiddle angle in eighths of a turn.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        top_addr = 3'd0;
        bot_addr = 3'd1;
        tw_sel   = 2'd0;
        case (cnt_q[3:2])
            2'd0: begin
                top_addr = {cnt_q[1:0], 1'b0};
                bot_addr = {cnt_q[1:0], 1'b1};
            end
            2'd1: begin
                top_addr = {cnt_q[1], 1'b0, cnt_q[0]};
                bot_addr = {cnt_q[1], 1'b1, cnt_q[0]};
                tw_sel   = {cnt_q[0], 1'b0};
            end
            default: begin
                top_addr = {1'b0, cnt_q[1:0]};
                bot_addr = {1'b1, cnt_q[1:0]};
                tw_sel   = cnt_q[1:0];
            end
        endcase
    end

    // Twiddle product W*B: exact for 1 and j, Q1.7 multiply with floor for the diagonals.
    always_comb begin
        a_re      = mem_re_q[top_addr];
        a_im      = mem_im_q[top_addr];
        b_re      = mem_re_q[bot_addr];
        b_im      = mem_im_q[bot_addr];
        b_sum     = PW'(b_re) + PW'(b_im);
        b_diff    = PW'(b_re) - PW'(b_im);
        p_sum     = b_sum * C_DIAG;
        p_diff    = b_diff * C_DIAG;
        p_sum_neg = -p_sum;
        wb_re     = b_re;
        wb_im     = b_im;
        case (tw_sel)
            2'd1: begin
                wb_re = IW'(p_diff >>> 7);
                wb_im = IW'(p_sum >>> 7);
            end
            2'd2: begin
                wb_re = -b_im;
                wb_im = b_re;
            end
            2'd3: begin
                wb_re = IW'(p_sum_neg >>> 7);
                wb_im = IW'(p_diff >>> 7);
            end
            default: ;
        endcase
    end

    // Next-state logic for the LOAD -> COMPUTE -> UNLOAD sequence and the working RAM.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mem_re_d   = mem_re_q;
        mem_im_d   = mem_im_q;
        out_real_d = out_real_q;
        out_imag_d = out_imag_q;
        out_last_d = out_last_q;
        case (state_q)
            ST_LOAD: begin
                if (bus.in_valid) begin
                    mem_re_d[rev3(cnt_q[2:0])] = IW'(bus.in_real);
                    mem_im_d[rev3(cnt_q[2:0])] = IW'(bus.in_imag);
                    if (cnt_q == 4'd7) begin
                        state_d = ST_COMPUTE;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            ST_COMPUTE: begin
                mem_re_d[top_addr] = a_re + wb_re;
                mem_im_d[top_addr] = a_im + wb_im;
                mem_re_d[bot_addr] = a_re - wb_re;
                mem_im_d[bot_addr] = a_im - wb_im;
                if (cnt_q == 4'd11) begin
                    // x[0] was finished early in stage 3, so it is already final here.
                    state_d    = ST_UNLOAD;
                    cnt_d      = 4'd0;
                    out_real_d = to_out(mem_re_q[0]);
                    out_imag_d = to_out(mem_im_q[0]);
                    out_last_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_UNLOAD: begin
                if (bus.out_ready) begin
                    if (cnt_q == 4'd7) begin
                        state_d    = ST_LOAD;
                        cnt_d      = 4'd0;
                        out_last_d = 1'b0;
                    end else begin
                        cnt_d      = cnt_q + 4'd1;
                        out_real_d = to_out(mem_re_q[cnt_q[2:0] + 3'd1]);
                        out_imag_d = to_out(mem_im_q[cnt_q[2:0] + 3'd1]);
                        out_last_d = (cnt_q == 4'd6);
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Working RAM update.
    always_ff @(posedge clk) begin
        // NOTE: the working RAM holds no state that matters after reset, so it is deliberately left unreset.
        mem_re_q <= mem_re_d;
        mem_im_q <= mem_im_d;
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            state_q    <= ST_LOAD;
            cnt_q      <= 4'd0;
            out_real_q <= '0;
            out_imag_q <= '0;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            out_real_q <= out_real_d;
            out_imag_q <= out_imag_d;
            out_last_q <= out_last_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_LOAD);
    assign bus.out_valid = (state_q == ST_UNLOAD);
    assign bus.out_real  = out_real_q;
    assign bus.out_imag  = out_imag_q;
    assign bus.out_last  = out_last_q;
endmodule
